// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and types for the receiver and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Width needed to hold a count of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_fifo_core.sv
// ============================================================================
// Module      : uart_rx_fifo_core
// Description : Circular FIFO storage with pointers and fill count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo_core
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 wr_data_i,
    input  logic                             wr_req_i,
    input  logic                             rd_ready_i,
    output logic [WIDTH-1:0]                 rd_data_o,
    output logic                             rd_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]       fill_o,
    output logic [$clog2(DEPTH+1)-1:0]       fill_next_o,
    output logic                             drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic             w_pop;
    logic             w_push;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts
    // a byte when the consumer takes the head simultaneously.
    always_comb begin
        w_pop    = (fill_q != '0) && rd_ready_i;
        w_push   = wr_req_i && ((fill_q != C_FULL) || w_pop);
        wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fill_d   = fill_q;
        if (w_push && !w_pop) begin
            fill_d = fill_q + CW'(1);
        end else if (!w_push && w_pop) begin
            fill_d = fill_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage is not reset; stale entries are hidden by rd_valid_o.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_valid_o  = (fill_q != '0);
    assign rd_data_o   = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign fill_o      = fill_q;
    assign fill_next_o = fill_d;
    assign drop_o      = wr_req_i && !w_push;

endmodule : uart_rx_fifo_core

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive buffer with valid/ready output, RTS and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [UART_DATA_W-1:0]       rx_data,
    input  logic                         rx_stb,
    output logic [UART_DATA_W-1:0]       out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         rts_n,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_AF_LEVEL = CW'(AF_LEVEL);

    logic [CW-1:0] w_fill_next;
    logic          w_drop;
    logic          rts_n_q, rts_n_d;
    logic          overflow_q, overflow_d;

    uart_rx_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .wr_data_i   (rx_data),
        .wr_req_i    (rx_stb),
        .rd_ready_i  (out_ready),
        .rd_data_o   (out_data),
        .rd_valid_o  (out_valid),
        .fill_o      (fill),
        .fill_next_o (w_fill_next),
        .drop_o      (w_drop)
    );

    // RTS follows the next-state fill so it moves in step with fill itself.
    always_comb begin
        rts_n_d    = (w_fill_next >= C_AF_LEVEL);
        overflow_d = overflow_q;
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rts_n_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rts_n_q    <= rts_n_d;
            overflow_q <= overflow_d;
        end
    end

    assign rts_n    = rts_n_q;
    assign overflow = overflow_q;

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_stb = 1'b0;
    logic          out_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic [CW-1:0] fill;
    logic          rts_n;
    logic          overflow;

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_stb    (rx_stb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .rts_n     (rts_n),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    byte unsigned mdl[$];
    byte unsigned drained[$];
    byte unsigned sent[$];
    bit m_ovf = 1'b0;
    bit m_rts = 1'b0;
    bit mon_en = 1'b0;
    bit m_pop, m_push, m_drop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded queue clipped at DEPTH entries.
    always @(posedge clk) begin
        if (rst) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_rts = 1'b0;
        end else begin
            m_pop  = (mdl.size() > 0) && out_ready;
            m_push = rx_stb && ((mdl.size() < DEPTH) || m_pop);
            m_drop = rx_stb && !m_push;
            if (m_pop)  void'(mdl.pop_front());
            if (m_push) mdl.push_back(rx_data);
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_rts = (mdl.size() >= AF);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_fill",  32'(fill), 32'(mdl.size()));
            chk("mon_valid", 32'(out_valid), 32'(mdl.size() != 0));
            chk("mon_data",  32'(out_data), (mdl.size() != 0) ? 32'(mdl[0]) : 32'h0);
            chk("mon_rts",   32'(rts_n), 32'(m_rts));
            chk("mon_ovf",   32'(overflow), 32'(m_ovf));
            chk("mon_fillmax", 32'(fill <= DEPTH), 32'h1);
            if (out_valid && out_ready && !rst) drained.push_back(out_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            rx_stb  = 1'b1;
            rx_data = 8'(base + i);
            cyc();
        end
        rx_stb = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) cyc();
        out_ready = 1'b0;
        chk("drain_done", 32'(out_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_fill", 32'(fill), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_rts", 32'(rts_n), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);

        // 1: single byte then pop
        rx_stb = 1'b1; rx_data = 8'hA5;
        cyc();
        rx_stb = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_fill", 32'(fill), 32'h1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t1_pop_fill", 32'(fill), 32'h0);
        chk("t1_pop_valid", 32'(out_valid), 32'h0);
        chk("t1_pop_data", 32'(out_data), 32'h0);

        // 2: fill to 16, rts edge, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            rx_stb = 1'b1; rx_data = 8'(i);
            cyc();
            chk("t2_rts", 32'(rts_n), 32'((i + 1) >= AF));
        end
        rx_stb = 1'b0;
        chk("t2_full", 32'(fill), 32'd16);
        drained.delete();
        drain();
        chk("t2_cnt", 32'(drained.size()), 32'd16);
        foreach (drained[i]) chk("t2_order", 32'(drained[i]), 32'(i));
        chk("t2_rts_low", 32'(rts_n), 32'h0);

        // 3: overflow drop and clear
        write_n(DEPTH, 0);
        rx_stb = 1'b1; rx_data = 8'hEE;
        cyc();
        rx_stb = 1'b0;
        chk("t3_ovf", 32'(overflow), 32'h1);
        chk("t3_fill", 32'(fill), 32'd16);
        drained.delete();
        drain();
        chk("t3_cnt", 32'(drained.size()), 32'd16);
        foreach (drained[i]) chk("t3_order", 32'(drained[i]), 32'(i));
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("t3_clr", 32'(overflow), 32'h0);

        // 4: full with simultaneous pop and write
        write_n(DEPTH, 0);
        rx_stb = 1'b1; rx_data = 8'h77; out_ready = 1'b1;
        cyc();
        rx_stb = 1'b0; out_ready = 1'b0;
        chk("t4_fill", 32'(fill), 32'd16);
        chk("t4_ovf", 32'(overflow), 32'h0);
        drained.delete();
        drain();
        chk("t4_cnt", 32'(drained.size()), 32'd16);
        chk("t4_first", 32'(drained[0]), 32'h01);
        chk("t4_last", 32'(drained[15]), 32'h77);

        // 5: random interleaved writes, pops and gaps
        drained.delete();
        sent.delete();
        for (int n = 0; n < 40; n++) begin
            rx_stb    = 1'b1;
            rx_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            sent.push_back(rx_data);
            cyc();
            rx_stb = 1'b0;
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                out_ready = 1'($urandom_range(0, 1));
                cyc();
            end
        end
        drain();
        if (!overflow) begin
            chk("t5_cnt", 32'(drained.size()), 32'(sent.size()));
            foreach (sent[i]) chk("t5_order", 32'(drained[i]), 32'(sent[i]));
        end

        // 6: reset with content, then overflow set beats clear
        write_n(5, 8'h30);
        chk("t6_pre", 32'(fill), 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_fill", 32'(fill), 32'h0);
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_rts", 32'(rts_n), 32'h0);
        write_n(DEPTH, 8'h40);
        rx_stb = 1'b1; rx_data = 8'h99; ovf_clr = 1'b1;
        cyc();
        rx_stb = 1'b0; ovf_clr = 1'b0;
        chk("t6_setprio", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("t6_clr", 32'(overflow), 32'h0);
        drain();

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx_fifo

`default_nettype wire
